// File: rtl/mask_stream_tx.sv
// mask_stream_tx: reduces the thresholded pixel stream to one mask bit per
// (1<<SCALE_LOG2)-square block and transmits the blocks in raster order,
// each as x/y/mask with a valid strobe, followed by an end-of-frame pulse.
//
// Optional feature macro: MASK_OR_REDUCE_EN
//   defined   -> block bit is the OR of every valid pixel in the block
//   undefined -> block bit is the pixel at the block's top-left corner
//
// Ports:
//   clk_in, rst_in_n            clock, asynchronous active-low reset
//   hcount_in, vcount_in        input pixel column / row
//   pixel_valid_in, mask_in     pixel qualifier and thresholded pixel bit
//   x_out, y_out, mask_out      block coordinate and block bit (held between strobes)
//   block_valid_out             1-cycle strobe, one cycle after the block's last pixel
//   new_frame_out               1-cycle pulse, the cycle after the final block strobe
//
// Latency: 1 cycle from a block's bottom-right pixel to its strobe.
// No backpressure: every valid pixel is consumed in the cycle it is presented.
module mask_stream_tx #(
  parameter int IN_WIDTH   = 1280,
  parameter int IN_HEIGHT  = 720,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pixel_valid_in,
  input  logic        mask_in,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic        mask_out,
  output logic        block_valid_out,
  output logic        new_frame_out
);

  localparam int ROW_W  = IN_WIDTH >> SCALE_LOG2;
  localparam int COL_H  = IN_HEIGHT >> SCALE_LOG2;
  localparam int IDX_W  = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int LAST_X = ROW_W - 1;
  localparam int LAST_Y = COL_H - 1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    STREAM    = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [8:0]         x_q;
  logic [7:0]         y_q;
  logic               mask_q;
  logic               bvld_q;

  logic               pix_ok;
  logic               sof;
  logic               h_first, h_last, v_first, v_last;
  logic [IDX_W-1:0]   idx;
  logic [8:0]         x_blk;
  logic [7:0]         y_blk;
  logic               last_emitted;
  logic               process;
  logic               emit;
  logic               blk_bit;

  assign pix_ok  = pixel_valid_in
                && (hcount_in < 11'(IN_WIDTH))
                && (vcount_in < 10'(IN_HEIGHT));
  assign sof     = pix_ok && (hcount_in == '0) && (vcount_in == '0);
  assign h_first = (hcount_in[SCALE_LOG2-1:0] == '0);
  assign h_last  = (hcount_in[SCALE_LOG2-1:0] == '1);
  assign v_first = (vcount_in[SCALE_LOG2-1:0] == '0);
  assign v_last  = (vcount_in[SCALE_LOG2-1:0] == '1);
  assign idx     = IDX_W'(hcount_in >> SCALE_LOG2);
  assign x_blk   = 9'(hcount_in >> SCALE_LOG2);
  assign y_blk   = 8'(vcount_in >> SCALE_LOG2);

  // The final block's strobe is on the outputs this cycle; the frame-done
  // state follows it so the end-of-frame pulse never overlaps a strobe.
  assign last_emitted = bvld_q && (x_q == 9'(LAST_X)) && (y_q == 8'(LAST_Y));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    process = 1'b0;
    emit    = 1'b0;
    blk_bit = 1'b0;

    unique case (state_q)
      WAIT_SYNC: begin
        if (sof) begin
          state_d = STREAM;
          process = 1'b1;
        end
      end
      STREAM: begin
        // Frame completion wins over anything presented in the same cycle.
        if (last_emitted) state_d = DONE;
        else              process = pix_ok;
      end
      DONE:    state_d = WAIT_SYNC;
      default: state_d = WAIT_SYNC;
    endcase

    if (process) begin
      // Frame (re)start: drop any partial block rows from the previous frame.
      if (sof) row_d = '0;
`ifdef MASK_OR_REDUCE_EN
      // First pixel of a block overwrites, the rest OR into the column bit.
      blk_bit = (h_first && v_first) ? mask_in : (row_q[idx] | mask_in);
`else
      // Only the block's top-left pixel is sampled; the bit holds it until emission.
      blk_bit = (h_first && v_first) ? mask_in : row_q[idx];
`endif
      emit       = h_last && v_last;
      row_d[idx] = emit ? 1'b0 : blk_bit;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= WAIT_SYNC;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mask_q  <= 1'b0;
      bvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bvld_q  <= emit;
      if (emit) begin
        x_q    <= x_blk;
        y_q    <= y_blk;
        mask_q <= blk_bit;
      end
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign mask_out        = mask_q;
  assign block_valid_out = bvld_q;
  assign new_frame_out   = (state_q == DONE);

endmodule

// File: tb/tb_mask_stream_tx.sv
module tb_mask_stream_tx;

  // Reduced frame keeps every scenario to a few thousand cycles.
  localparam int W  = 64;
  localparam int H  = 24;
  localparam int BW = W / 4;
  localparam int BH = H / 4;
  localparam int NB = BW * BH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic        pv = 1'b0;
  logic        mi = 1'b0;
  logic [8:0]  x_o;
  logic [7:0]  y_o;
  logic        m_o;
  logic        bv_o;
  logic        nf_o;

  always #5 clk = ~clk;

  mask_stream_tx #(.IN_WIDTH(W), .IN_HEIGHT(H), .SCALE_LOG2(2)) dut (
    .clk_in          (clk),
    .rst_in_n        (rst_n),
    .hcount_in       (hc),
    .vcount_in       (vc),
    .pixel_valid_in  (pv),
    .mask_in         (mi),
    .x_out           (x_o),
    .y_out           (y_o),
    .mask_out        (m_o),
    .block_valid_out (bv_o),
    .new_frame_out   (nf_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit fm [0:H-1][0:W-1];

  typedef struct {
    int x;
    int y;
    int m;
    int cyc;
  } blk_t;

  blk_t sq[$];
  blk_t ref_q[$];
  int   nfq[$];
  int   coinc = 0;
  int   cyc = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    blk_t b;
    cyc <= cyc + 1;
    if (bv_o) begin
      b.x = int'(x_o); b.y = int'(y_o); b.m = int'(m_o); b.cyc = cyc;
      sq.push_back(b);
    end
    if (nf_o) nfq.push_back(cyc);
    if (bv_o && nf_o) coinc <= coinc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: block bit straight from the frame picture.
  function automatic int model_blk(input int bx, input int by);
    int r;
    r = 0;
`ifdef MASK_OR_REDUCE_EN
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        r = r | int'(fm[4*by+dy][4*bx+dx]);
`else
    r = int'(fm[4*by][4*bx]);
`endif
    return r;
  endfunction

  task automatic clear_fm();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fm[y][x] = 1'b0;
  endtask

  task automatic rand_fm(input int pct);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fm[y][x] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic drive(input int h, input int v, input bit valid, input bit m);
    @(negedge clk);
    hc = 11'(h); vc = 10'(v); pv = valid; mi = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 2047), $urandom_range(0, 1023), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Raster feed from (h0,v0) up to row v1-1, with random gaps and
  // optional valid-but-out-of-range pixels carrying mask=1.
  task automatic feed(input int v0, input int h0, input int v1, input int gap_pct, input int oob_pct);
    for (int v = v0; v < v1; v++) begin
      for (int h = ((v == v0) ? h0 : 0); h < W; h++) begin
        int g;
        g = 0;
        while (g < 6 && $urandom_range(0, 99) < gap_pct) begin
          drive($urandom_range(0, 2047), $urandom_range(0, 1023), 1'b0, 1'($urandom_range(0, 1)));
          g++;
        end
        if ($urandom_range(0, 99) < oob_pct) begin
          if ($urandom_range(0, 1) == 0) drive($urandom_range(W, 2047), $urandom_range(0, 1023), 1'b1, 1'b1);
          else                           drive($urandom_range(0, W-1), $urandom_range(H, 1023), 1'b1, 1'b1);
        end
        drive(h, v, 1'b1, fm[v][h]);
      end
    end
  endtask

  task automatic clear_mon();
    sq.delete();
    nfq.delete();
    coinc = 0;
  endtask

  // Full-frame check against the model, then clears the monitor.
  task automatic check_frame(input string tag);
    int n;
    int bad;
    int gap;
    n   = sq.size();
    bad = 0;
    check({tag, " strobe count"}, n, NB);
    for (int i = 0; i < n && i < NB; i++) begin
      if (sq[i].x != i % BW || sq[i].y != i / BW || sq[i].m != model_blk(i % BW, i / BW)) bad++;
    end
    check({tag, " block order/values bad"}, bad, 0);
    check({tag, " new_frame count"}, nfq.size(), 1);
    gap = (nfq.size() > 0 && n > 0) ? nfq[0] - sq[n-1].cyc : -1;
    check({tag, " new_frame after last strobe"}, gap, 1);
    check({tag, " new_frame coincident with strobe"}, coinc, 0);
    clear_mon();
  endtask

  typedef struct {
    int px;
    int py;
    bit hit_or;
    bit hit_dec;
    int bx;
    int by;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl = '{
      '{5,  9,  1'b1, 1'b0, 1,  2},
      '{4,  8,  1'b1, 1'b1, 1,  2},
      '{0,  0,  1'b1, 1'b1, 0,  0},
      '{63, 23, 1'b1, 1'b0, 15, 5},
      '{60, 20, 1'b1, 1'b1, 15, 5},
      '{7,  5,  1'b1, 1'b0, 1,  1}
    };

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset outputs", int'({x_o, y_o, m_o, bv_o, nf_o}), 0);
    rst_n = 1'b1;
    idle(2);

    // Reset mid-stream, then the remainder of that frame must be discarded.
    clear_fm();
    feed(0, 0, 10, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", int'({x_o, y_o, m_o, bv_o, nf_o}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    feed(10, 0, H, 0, 0);
    idle(4);
    check("post-reset tail strobes", sq.size(), 0);
    check("post-reset tail new_frame", nfq.size(), 0);
    clear_mon();
    feed(0, 0, H, 0, 0);
    idle(4);
    check_frame("zero frame");

    // Single-pixel vectors.
    for (int t = 0; t < 6; t++) begin
      int ones;
      int pos;
      bit hit;
      clear_fm();
      fm[tbl[t].py][tbl[t].px] = 1'b1;
      feed(0, 0, H, 0, 0);
      idle(4);
`ifdef MASK_OR_REDUCE_EN
      hit = tbl[t].hit_or;
`else
      hit = tbl[t].hit_dec;
`endif
      ones = 0;
      pos  = -1;
      foreach (sq[i]) if (sq[i].m == 1) begin
        ones++;
        if (pos < 0) pos = sq[i].x * 1000 + sq[i].y;
      end
      check($sformatf("vec%0d mask-1 block count", t), ones, hit ? 1 : 0);
      check($sformatf("vec%0d mask-1 block position", t), pos, hit ? tbl[t].bx * 1000 + tbl[t].by : -1);
      check_frame($sformatf("vec%0d", t));
    end

    // Random picture, gap-free then with 50% gaps: identical block stream.
    rand_fm(30);
    feed(0, 0, H, 0, 0);
    idle(4);
    ref_q = sq;
    check_frame("random no-gap");
    feed(0, 0, H, 50, 0);
    idle(4);
    begin
      int diff;
      diff = (sq.size() == ref_q.size()) ? 0 : 1000;
      for (int i = 0; i < sq.size() && i < ref_q.size(); i++)
        if (sq[i].x != ref_q[i].x || sq[i].y != ref_q[i].y || sq[i].m != ref_q[i].m) diff++;
      check("gapped vs gap-free stream diffs", diff, 0);
    end
    check_frame("random gapped");

    // Out-of-range valid pixels with mask=1 must be ignored.
    rand_fm(50);
    feed(0, 0, H, 20, 10);
    idle(4);
    check_frame("out-of-range injected");

    // Feed starting mid-frame after reset: silent until (0,0).
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clear_mon();
    rand_fm(40);
    feed(12, 32, H, 0, 0);
    idle(4);
    check("mid-frame start strobes", sq.size(), 0);
    check("mid-frame start new_frame", nfq.size(), 0);
    clear_mon();
    feed(0, 0, H, 0, 0);
    idle(4);
    check_frame("after mid-frame start");

    // Restart at (0,0) in the middle of a block row.
    rand_fm(60);
    feed(0, 0, 14, 10, 0);
    idle(2);
    check("restart partial new_frame", nfq.size(), 0);
    clear_mon();
    rand_fm(40);
    feed(0, 0, H, 10, 0);
    idle(4);
    check("restart first block", (sq.size() > 0) ? sq[0].x * 1000 + sq[0].y : -1, 0);
    check_frame("restarted frame");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
